// File: rtl/nano_dsi_lane_pkg.sv
// nano_dsi_lane_pkg: lane state encoding, LP line codes and the default sync byte.
package nano_dsi_lane_pkg;
  typedef enum logic [3:0] {
    S_LP11, S_LP01, S_LP00, S_HS_ZERO, S_HS_CLK, S_HS_SYNC, S_HS_DATA,
    S_HS_TRAIL, S_HS_EXIT, S_ULPS_LP10, S_ULPS_LP00, S_WAKE_LP10
  } lane_state_e;
  localparam logic [1:0] LP11 = 2'b11;
  localparam logic [1:0] LP10 = 2'b10;
  localparam logic [1:0] LP01 = 2'b01;
  localparam logic [1:0] LP00 = 2'b00;
  localparam logic [7:0] DEF_SYNC_BYTE = 8'hB8;
  // {p,n} line levels driven while in state s; every HS state parks LP at 00
  function automatic logic [1:0] lp_code(input lane_state_e s);
    return (s == S_LP11 || s == S_HS_EXIT) ? LP11 :
           (s == S_LP01) ? LP01 :
           (s == S_ULPS_LP10 || s == S_WAKE_LP10) ? LP10 : LP00;
  endfunction
  function automatic logic hs_on(input lane_state_e s);
    return s inside {S_HS_ZERO, S_HS_CLK, S_HS_SYNC, S_HS_DATA, S_HS_TRAIL};
  endfunction
endpackage

// File: rtl/nano_dsi_lane_timer.sv
// nano_dsi_lane_timer: dwell down-counter, loaded on every state change, trig while zero.
// Ports: clk, rst (async, active-high), load_i + val_i (reload), trig_o (count is zero).
module nano_dsi_lane_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         trig_o
);
  logic [W-1:0] cnt_q;
  assign trig_o = cnt_q == '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= load_i ? val_i : (trig_o ? cnt_q : cnt_q - W'(1));
endmodule

// File: rtl/nano_dsi_lane.sv
// nano_dsi_lane: MIPI D-PHY lane sequencer (clock lane MODE=0, data lane MODE=1).
// Ports: clk, rst (async, active-high); hs_req_i/hs_rdy_o burst control; ulps_req_i/ulps_active_o;
//   data_i/data_valid_i/data_ready_o byte handshake, err_underrun_o; cfg_*_i dwell = cfg+1 cycles;
//   lp_p_o/lp_n_o, hs_oe_o, hs_bits_o registered IOB drives ([0] rising UI, [1] falling UI).
// NANO_DSI_ULPS_EN enables the ULPS entry/wakeup path; without it ulps_req_i is ignored.
module nano_dsi_lane
  import nano_dsi_lane_pkg::*;
#(
  parameter int         MODE      = 0,
  parameter int         TIMER_W   = 8,
  parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hs_req_i,
  output logic               hs_rdy_o,
  input  logic               ulps_req_i,
  output logic               ulps_active_o,
  input  logic [7:0]         data_i,
  input  logic               data_valid_i,
  output logic               data_ready_o,
  output logic               err_underrun_o,
  input  logic [TIMER_W-1:0] cfg_lpx_i,
  input  logic [TIMER_W-1:0] cfg_hs_prep_i,
  input  logic [TIMER_W-1:0] cfg_hs_zero_i,
  input  logic [TIMER_W-1:0] cfg_hs_trail_i,
  input  logic [TIMER_W-1:0] cfg_hs_exit_i,
  input  logic [TIMER_W-1:0] cfg_wakeup_i,
  output logic               lp_p_o,
  output logic               lp_n_o,
  output logic               hs_oe_o,
  output logic [1:0]         hs_bits_o
);
  lane_state_e        state_q, state_d;
  logic [7:0]         sh_q, sh_d;
  logic [1:0]         ph_q, ph_d;
  logic [1:0]         lp_q, hs_bits_q, bits_d;
  logic               hs_oe_q, trig, shifting, bnd, ulps_go;
  logic [TIMER_W-1:0] tval;
`ifdef NANO_DSI_ULPS_EN
  assign ulps_go = ulps_req_i;
`else
  logic unused_ulps;
  assign ulps_go = 1'b0;
  assign unused_ulps = ulps_req_i;
`endif
  assign shifting = (MODE != 0) && (state_q == S_HS_SYNC || state_q == S_HS_DATA);
  // byte boundary = last of the four 2-bit phases of the byte on the wire
  assign bnd = shifting && ph_q == 2'd3;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LP11:     state_d = hs_req_i ? S_LP01 : (ulps_go ? S_ULPS_LP10 : S_LP11);
      S_LP01:     if (trig) state_d = S_LP00;
      S_LP00:     if (trig) state_d = S_HS_ZERO;
      S_HS_ZERO:  if (trig) state_d = (MODE != 0) ? S_HS_SYNC : S_HS_CLK;
      S_HS_CLK:   if (!hs_req_i) state_d = S_HS_TRAIL;
      S_HS_SYNC:  if (bnd) state_d = (data_valid_i || hs_req_i) ? S_HS_DATA : S_HS_TRAIL;
      S_HS_DATA:  if (bnd && !data_valid_i && !hs_req_i) state_d = S_HS_TRAIL;
      S_HS_TRAIL: if (trig) state_d = S_HS_EXIT;
      S_HS_EXIT:  if (trig) state_d = S_LP11;
`ifdef NANO_DSI_ULPS_EN
      S_ULPS_LP10: if (trig) state_d = S_ULPS_LP00;
      S_ULPS_LP00: if (!ulps_req_i) state_d = S_WAKE_LP10;
      S_WAKE_LP10: if (trig) state_d = S_LP11;
`endif
      default:    state_d = S_LP11;
    endcase
  end
  assign tval = (state_d == S_LP01 || state_d == S_ULPS_LP10) ? cfg_lpx_i :
                (state_d == S_LP00)      ? cfg_hs_prep_i :
                (state_d == S_HS_ZERO)   ? cfg_hs_zero_i :
                (state_d == S_HS_TRAIL)  ? cfg_hs_trail_i :
                (state_d == S_HS_EXIT)   ? cfg_hs_exit_i :
                (state_d == S_WAKE_LP10) ? cfg_wakeup_i : '0;
  nano_dsi_lane_timer #(.W(TIMER_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (state_d != state_q),
    .val_i  (tval),
    .trig_o (trig)
  );
  // on the final boundary the register is filled with ~bit7 so trail just replays it
  assign sh_d = (state_q == S_HS_ZERO) ? SYNC_BYTE :
                bnd ? (data_valid_i ? data_i : (hs_req_i ? 8'h00 : {8{~sh_q[1]}})) :
                shifting ? {2'b00, sh_q[7:2]} : sh_q;
  assign ph_d = shifting ? ph_q + 2'd1 : 2'd0;
  assign bits_d = (state_q == S_HS_CLK) ? 2'b01 :
                  ((MODE != 0) && (shifting || state_q == S_HS_TRAIL)) ? sh_q[1:0] : 2'b00;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= S_LP11;
      sh_q      <= '0;
      ph_q      <= '0;
      lp_q      <= LP11;
      hs_oe_q   <= 1'b0;
      hs_bits_q <= 2'b00;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      ph_q      <= ph_d;
      lp_q      <= lp_code(state_q);
      hs_oe_q   <= hs_on(state_q);
      hs_bits_q <= bits_d;
    end
  assign lp_p_o         = lp_q[1];
  assign lp_n_o         = lp_q[0];
  assign hs_oe_o        = hs_oe_q;
  assign hs_bits_o      = hs_bits_q;
  assign hs_rdy_o       = state_q == S_HS_CLK || state_q == S_HS_DATA;
  assign ulps_active_o  = state_q == S_ULPS_LP00;
  assign data_ready_o   = bnd && data_valid_i;
  assign err_underrun_o = bnd && !data_valid_i && hs_req_i;
endmodule
